// File: rtl/raw_pattern_gen.sv
// Raw Bayer test-pattern generator: ramp, colour bars, checkerboard and constant level with frame timing.
// Define PATGEN_LFSR_EN to replace the mode-3 constant level with a 16-bit Fibonacci LFSR.
module raw_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 4
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iEN,
   input  logic [1:0]  iMODE,
   input  logic [11:0] iLEVEL,
   output logic [11:0] oDATA,
   output logic        oDVAL,
   output logic [15:0] oX_Cont,
   output logic [15:0] oY_Cont,
   output logic        oFRAME_START,
   output logic        oBUSY
);

   // state  | meaning
   // IDLE   | waiting for iEN, outputs quiet
   // ACTIVE | emitting pixel (x_q, y_q)
   // HBLANK | line gap, cnt_q counts down to 0
   // VBLANK | frame gap, cnt_q counts down to 0
   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

   localparam int          LINE_CYC = H_ACTIVE + H_BLANK;
   localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
   localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
   localparam logic [31:0] HB_LOAD  = 32'(H_BLANK - 1);
   localparam logic [31:0] VB_LOAD  = 32'(V_BLANK * LINE_CYC - 1);

   state_t      state_q, state_d;
   logic [15:0] x_q, x_d, y_q, y_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  mode_q, mode_d;
`ifdef PATGEN_LFSR_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   logic [15:0] lfsr_q, lfsr_d;
`else
   logic [11:0] level_q, level_d;
`endif

   logic        line_end, frame_end, frame_go;
   logic [11:0] data_q, data_d, pix;
   logic        dval_q, dval_d, fs_q, fs_d, busy_q, busy_d;
   logic [15:0] ox_q, ox_d, oy_q, oy_d;
   logic [2:0]  bar;
   logic        bar_on;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      line_end  = 1'b0;
      frame_end = 1'b0;
      frame_go  = 1'b0;
`ifdef PATGEN_LFSR_EN
      lfsr_d    = (state_q == ACTIVE) ?
                  {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
`else
      level_d   = level_q;
`endif
      case (state_q)
         IDLE: begin
            if (iEN) frame_go = 1'b1;
         end
         ACTIVE: begin
            if (x_q == X_LAST) begin
               if (H_BLANK == 0) begin
                  line_end = 1'b1;
               end else begin
                  state_d = HBLANK;
                  cnt_d   = HB_LOAD;
               end
            end else begin
               x_d = x_q + 16'd1;
            end
         end
         HBLANK: begin
            if (cnt_q == 32'd0) line_end = 1'b1;
            else                cnt_d    = cnt_q - 32'd1;
         end
         VBLANK: begin
            if (cnt_q == 32'd0) frame_end = 1'b1;
            else                cnt_d     = cnt_q - 32'd1;
         end
         default: state_d = IDLE;
      endcase

      if (line_end) begin
         if (y_q == Y_LAST) begin
            if (V_BLANK == 0) begin
               frame_end = 1'b1;
            end else begin
               state_d = VBLANK;
               cnt_d   = VB_LOAD;
            end
         end else begin
            state_d = ACTIVE;
            x_d     = 16'd0;
            y_d     = y_q + 16'd1;
         end
      end

      // a frame in progress always runs to the end of VBLANK before iEN is looked at again
      if (frame_end) begin
         if (iEN) frame_go = 1'b1;
         else     state_d  = IDLE;
      end

      if (frame_go) begin
         state_d = ACTIVE;
         x_d     = 16'd0;
         y_d     = 16'd0;
         mode_d  = iMODE;
`ifdef PATGEN_LFSR_EN
         lfsr_d  = LFSR_SEED;
`else
         level_d = iLEVEL;
`endif
      end
   end

   always_comb begin
      bar = 3'((32'(x_q) * 32'd8) / 32'(H_ACTIVE));
      case ({y_q[0], x_q[0]})
         2'b01:   bar_on = bar[2];
         2'b10:   bar_on = bar[0];
         default: bar_on = bar[1];
      endcase
      case (mode_q)
         2'd0:    pix = x_q[11:0] + y_q[11:0];
         2'd1:    pix = {12{bar_on}};
         2'd2:    pix = {12{x_q[3] ^ y_q[3]}};
`ifdef PATGEN_LFSR_EN
         default: pix = lfsr_q[11:0];
`else
         default: pix = level_q;
`endif
      endcase
      dval_d = (state_q == ACTIVE);
      data_d = dval_d ? pix : 12'd0;
      fs_d   = dval_d && (x_q == 16'd0) && (y_q == 16'd0);
      ox_d   = x_q;
      oy_d   = y_q;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= IDLE;
         x_q     <= 16'd0;
         y_q     <= 16'd0;
         cnt_q   <= 32'd0;
         mode_q  <= 2'd0;
`ifdef PATGEN_LFSR_EN
         lfsr_q  <= LFSR_SEED;
`else
         level_q <= 12'd0;
`endif
         data_q  <= 12'd0;
         dval_q  <= 1'b0;
         fs_q    <= 1'b0;
         ox_q    <= 16'd0;
         oy_q    <= 16'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
`ifdef PATGEN_LFSR_EN
         lfsr_q  <= lfsr_d;
`else
         level_q <= level_d;
`endif
         data_q  <= data_d;
         dval_q  <= dval_d;
         fs_q    <= fs_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         busy_q  <= busy_d;
      end
   end

   assign oDATA        = data_q;
   assign oDVAL        = dval_q;
   assign oX_Cont      = ox_q;
   assign oY_Cont      = oy_q;
   assign oFRAME_START = fs_q;
   assign oBUSY        = busy_q;

endmodule

// File: tb/tb_raw_pattern_gen.sv
// Bench for raw_pattern_gen: frame-position reference model feeding a pixel scoreboard,
// plus a wide instance (640 columns) for colour-bar checks.
module tb_raw_pattern_gen;
   localparam int H = 4, V = 2, HB = 2, VB = 3;
   localparam int LINE = H + HB;
   localparam int FRAME = (V + VB) * LINE;
   localparam int WH = 640, WV = 2;
`ifdef PATGEN_LFSR_EN
   localparam bit LFSR_ON = 1'b1;
`else
   localparam bit LFSR_ON = 1'b0;
`endif

   logic        clk, rst_n, en, w_en;
   logic [1:0]  mode;
   logic [11:0] level;
   logic [11:0] oDATA, w_data;
   logic        oDVAL, oFS, oBUSY, w_dval, w_fs, w_busy;
   logic [15:0] oX, oY, w_x, w_y;

   raw_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)) u_dut (
      .iCLK(clk), .iRST(rst_n), .iEN(en), .iMODE(mode), .iLEVEL(level),
      .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX), .oY_Cont(oY),
      .oFRAME_START(oFS), .oBUSY(oBUSY));

   raw_pattern_gen #(.H_ACTIVE(WH), .V_ACTIVE(WV), .H_BLANK(2), .V_BLANK(1)) u_wide (
      .iCLK(clk), .iRST(rst_n), .iEN(w_en), .iMODE(2'd1), .iLEVEL(12'd0),
      .oDATA(w_data), .oDVAL(w_dval), .oX_Cont(w_x), .oY_Cont(w_y),
      .oFRAME_START(w_fs), .oBUSY(w_busy));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0, bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pix(int m, int lvl, int x, int y, int hact, int lf);
      int bar, on;
      case (m)
         0: return (x + y) % 4096;
         1: begin
            bar = (x * 8) / hact;
            if (y % 2 == 0 && x % 2 == 1)      on = (bar >> 2) & 1;
            else if (y % 2 == 1 && x % 2 == 0) on = bar & 1;
            else                               on = (bar >> 1) & 1;
            return on ? 4095 : 0;
         end
         2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 4095 : 0;
         default: return LFSR_ON ? (lf & 4095) : lvl;
      endcase
   endfunction

   function automatic int lfsr_next(int v);
      logic [15:0] s;
      s = 16'(v);
      return int'({s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]});
   endfunction

   typedef struct {int x; int y; int d; int fs;} pix_t;
   pix_t sb[$];

   // reference model: position within the frame, advanced once per clock
   int run = 0, pos = 0, m_mode = 0, m_lvl = 0, m_lf = 'hACE1, m_frames = 0;
   int exp_dval = 0, exp_busy = 0, exp_hold = 0, exp_hx = 0, exp_hy = 0;

   always @(posedge clk) begin
      int px, py;
      bit act;
      pix_t e;
      if (!rst_n) begin
         run = 0; exp_dval = 0; exp_busy = 0; exp_hold = 0;
      end else begin
         act = run != 0 && (pos / LINE) < V && (pos % LINE) < H;
         exp_dval = act;
         exp_hold = run != 0 && !act;
         if (exp_hold) begin
            exp_hx = H - 1;
            exp_hy = (pos / LINE < V) ? pos / LINE : V - 1;
         end
         if (act) begin
            px = pos % LINE; py = pos / LINE;
            e.x = px; e.y = py; e.fs = (pos == 0);
            e.d = pix(m_mode, m_lvl, px, py, H, m_lf);
            sb.push_back(e);
            m_lf = lfsr_next(m_lf);
         end
         if (run == 0) begin
            if (en) begin
               run = 1; pos = 0; m_mode = mode; m_lvl = level; m_lf = 'hACE1; m_frames++;
            end
         end else begin
            pos++;
            if (pos == FRAME) begin
               if (en) begin
                  pos = 0; m_mode = mode; m_lvl = level; m_lf = 'hACE1; m_frames++;
               end else begin
                  run = 0;
               end
            end
         end
         exp_busy = run;
      end
   end

   int fs_cnt = 0;
   always @(negedge clk) begin
      pix_t e;
      chk("dval", oDVAL, exp_dval);
      chk("busy", oBUSY, exp_busy);
      if (oFS) fs_cnt++;
      if (oDVAL) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty got pixel x=%0d y=%0d want none", oX, oY);
         end else begin
            e = sb.pop_front();
            chk("pix_x", oX, e.x);
            chk("pix_y", oY, e.y);
            chk("pix_data", oDATA, e.d);
            chk("pix_fs", oFS, e.fs);
         end
      end else begin
         chk("blank_data", oDATA, 0);
         chk("blank_fs", oFS, 0);
         if (exp_hold) begin
            chk("hold_x", oX, exp_hx);
            chk("hold_y", oY, exp_hy);
         end
      end
   end

   int wk = 0, w_pix = 0;
   always @(negedge clk) begin
      int wx, wy;
      if (w_dval) begin
         wx = wk % WH; wy = wk / WH;
         chk("bar_x", w_x, wx);
         chk("bar_y", w_y, wy);
         chk("bar_data", w_data, pix(1, 0, wx, wy, WH, 0));
         wk++;
         if (wk == WH * WV) wk = 0;
         w_pix++;
      end
   end

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (oBUSY && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", oBUSY, 0);
   endtask

   task automatic wait_pixel(input int x, input int y, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!(oDVAL && oX == x && oY == y) && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!(oDVAL && oX == x && oY == y)) begin
         bad++;
         $display("FAIL wait_pixel got x=%0d y=%0d dval=%0d want x=%0d y=%0d", oX, oY, oDVAL, x, y);
      end
   endtask

   task automatic check_first_pixel(input string nm);
      @(posedge clk); #1;
      chk({nm, "_edge1_dval"}, oDVAL, 0);
      @(posedge clk); #1;
      chk({nm, "_dval"}, oDVAL, 1);
      chk({nm, "_x"}, oX, 0);
      chk({nm, "_y"}, oY, 0);
      chk({nm, "_fs"}, oFS, 1);
   endtask

   initial begin
      logic [29:0] pat, want_pat;
      int f0, n;
      want_pat = 30'b111100_111100_000000_000000_000000;
      rst_n = 1'b0; en = 1'b0; w_en = 1'b0; mode = 2'd0; level = 12'd0;
      #2;
      chk("rst_data", oDATA, 0);
      chk("rst_dval", oDVAL, 0);
      chk("rst_busy", oBUSY, 0);
      chk("rst_x", oX, 0);
      chk("rst_y", oY, 0);
      chk("rst_fs", oFS, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // colour bars on the 640-wide instance, one frame
      w_en = 1'b1;
      @(negedge clk);
      w_en = 1'b0;
      n = 0;
      while (w_busy && n < 2200) begin
         @(negedge clk);
         n++;
      end
      chk("wide_idle", w_busy, 0);
      chk("wide_pixels", w_pix, WH * WV);

      // continuous ramp: latency, valid pattern over one frame
      en = 1'b1; mode = 2'd0;
      check_first_pixel("ramp");
      chk("ramp_data0", oDATA, 0);
      pat = 30'd1;
      for (int i = 1; i < 30; i++) begin
         @(posedge clk); #1;
         pat = {pat[28:0], oDVAL};
      end
      chk("dval_pattern", int'(pat), int'(want_pat));
      repeat (45) @(negedge clk);
      en = 1'b0;
      wait_idle(2 * FRAME);

      // single-cycle run request gives exactly one frame
      f0 = fs_cnt;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      wait_idle(2 * FRAME);
      chk("pulse_frames", fs_cnt - f0, 1);

      // mode change mid-frame only affects the following frame
      en = 1'b1; mode = 2'd0; level = 12'h5A5;
      repeat (12) @(negedge clk);
      mode = 2'd3;
      repeat (40) @(negedge clk);
      en = 1'b0;
      wait_idle(2 * FRAME);

      // randomized run requests, modes and levels
      for (int s = 0; s < 25; s++) begin
         en = ($urandom_range(0, 3) != 0);
         mode = 2'($urandom_range(0, 3));
         level = 12'($urandom);
         repeat ($urandom_range(1, 45)) @(negedge clk);
      end
      en = 1'b0;
      wait_idle(2 * FRAME);

      // reset mid-frame at pixel (2,1)
      en = 1'b1; mode = 2'd0;
      wait_pixel(2, 1, 3 * FRAME);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_data", oDATA, 0);
      chk("mid_rst_dval", oDVAL, 0);
      chk("mid_rst_busy", oBUSY, 0);
      chk("mid_rst_x", oX, 0);
      chk("mid_rst_y", oY, 0);
      chk("mid_rst_fs", oFS, 0);
      run = 0; exp_dval = 0; exp_busy = 0; exp_hold = 0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_first_pixel("restart");
      repeat (35) @(negedge clk);
      en = 1'b0;
      wait_idle(2 * FRAME);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("frame_starts", fs_cnt, m_frames);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
